// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode slice: widths, control encodings, fetch states.
package isa_pkg;

  localparam int unsigned XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  localparam logic [3:0]  CONTROL = 4'b1111;
  localparam logic [11:0] HALT    = 12'hFFF;
  localparam logic [11:0] RESET   = 12'hAAA;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry data+pc holding register that catches an imem response arriving while stalled.
module fetch_skid_buffer
  import isa_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  drain_i,
  input  logic  flush_i,
  input  word_t data_i,
  input  word_t pc_i,
  output logic  valid_o,
  output word_t data_o,
  output word_t pc_o
);

  logic  valid_q;
  word_t data_q;
  word_t pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem interface, skid on stall, redirect/halt/soft reset.
// Optional build macro FETCH_COUNT_EN adds a saturating accepted-instruction counter output.
module fetch_unit
  import isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic        stall_pi,
  input  logic        redirect_pi,
  input  logic [15:0] redirect_target_pi,
  input  logic        halt_pi,
  input  logic        rst_cmd_pi,
  output logic        imem_en_po,
  output logic [15:0] imem_addr_po,
  input  logic [15:0] imem_data_pi,
  output logic [15:0] instr_po,
  output logic [15:0] instr_pc_po,
  output logic        instr_valid_po,
  output logic        halted_po
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0] fetch_count_po
`endif
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  logic         pend_q, pend_d;
  word_t        pend_pc_q, pend_pc_d;
  word_t        instr_q, instr_d;
  word_t        instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;

  logic  issue;
  logic  skid_load, skid_drain, skid_flush;
  logic  skid_valid;
  word_t skid_data, skid_pc;

  assign issue = (state_q == RUN) && !stall_pi && !redirect_pi;

  fetch_skid_buffer u_skid (
    .clk_i   (clk_pi),
    .rst_i   (reset_pi),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (skid_flush),
    .data_i  (imem_data_pi),
    .pc_i    (pend_pc_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_flush = 1'b0;

    if (rst_cmd_pi) begin
      state_d    = RUN;
      pc_d       = RESET_PC;
      valid_d    = 1'b0;
      skid_flush = 1'b1;
    end else if (state_q == HALTED) begin
      valid_d    = 1'b0;
      skid_flush = 1'b1;
    end else if (redirect_pi) begin
      pc_d       = redirect_target_pi;
      valid_d    = 1'b0;
      skid_flush = 1'b1;
    end else begin
      if (issue) begin
        pc_d      = pc_q + 16'd1;
        pend_d    = 1'b1;
        pend_pc_d = pc_q;
      end
      if (halt_pi && valid_q && !stall_pi) begin
        state_d    = HALTED;
        valid_d    = 1'b0;
        pend_d     = 1'b0;
        skid_flush = 1'b1;
      end else if (stall_pi) begin
        // outputs hold; a response landing now is parked in the skid entry
        skid_load = pend_q;
      end else if (skid_valid) begin
        instr_d    = skid_data;
        instr_pc_d = skid_pc;
        valid_d    = 1'b1;
        skid_drain = 1'b1;
      end else if (pend_q) begin
        instr_d    = imem_data_pi;
        instr_pc_d = pend_pc_q;
        valid_d    = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_en_po     = issue;
  assign imem_addr_po   = pc_q;
  assign instr_po       = instr_q;
  assign instr_pc_po    = instr_pc_q;
  assign instr_valid_po = valid_q;
  assign halted_po      = (state_q == HALTED);

`ifdef FETCH_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (rst_cmd_pi) begin
      fcnt_d = '0;
    end else if (valid_q && !stall_pi && (fcnt_q != '1)) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign fetch_count_po = fcnt_q;
`endif

endmodule
